// File: rtl/count_tracker.sv
// count_tracker: follows a loadable modulo counter sample by sample, predicts
// each next value, and reports lock, mismatches and verified wraps to 0.
// Counts above MOD_MAX (possible on a 4-bit bus) are treated like MOD_MAX and
// predict 0.
module count_tracker #(
  parameter int MOD_MAX   = 13,
  parameter int ERR_LIMIT = 3,
  parameter int WRAP_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cnt_in,
  input  logic              load_in,
  input  logic              clr,
  output logic              locked,
  output logic [3:0]        expected,
  output logic              mismatch,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {IDLE, ACQ, CHECK} state_t;

  state_t     state;
  logic [3:0] prev_v;
  logic       prev_l;
  logic [3:0] miss_cnt;

  // Next-count prediction; anything at or beyond the modulus returns to 0.
  function automatic logic [3:0] pred(input logic [3:0] v);
    if (int'(v) >= MOD_MAX) return 4'd0;
    return v + 4'd1;
  endfunction

  logic cmp_en;    // a comparison happens on this edge
  logic match;     // sampled value equals prediction
  logic at_top;    // previous sample sits at or above the modulus
  logic miss_hit;  // mismatch that counts (only while locked)
  logic wrap_hit;  // verified wrap to 0
  logic drop;      // consecutive-miss limit reached

  assign cmp_en   = (state != IDLE) && !prev_l;
  assign match    = (cnt_in == pred(prev_v));
  assign at_top   = (int'(prev_v) >= MOD_MAX);
  assign miss_hit = cmp_en && (state == CHECK) && !match;
  assign wrap_hit = cmp_en && (state == CHECK) && match && at_top;
  assign drop     = miss_hit && (miss_cnt == 4'(ERR_LIMIT - 1));

  // Sample registers and the prediction output; re-seeded every edge, which
  // is also what a load needs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_v   <= 4'd0;
      prev_l   <= 1'b0;
      expected <= 4'd0;
    end else begin
      prev_v   <= cnt_in;
      prev_l   <= load_in;
      expected <= pred(cnt_in);
    end
  end

  // Tracking FSM with registered lock flag and miss counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      locked   <= 1'b0;
      miss_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: state <= ACQ;
        ACQ: begin
          if (cmp_en && match) begin
            state  <= CHECK;
            locked <= 1'b1;
          end
        end
        CHECK: begin
          if (cmp_en) begin
            if (match) begin
              miss_cnt <= 4'd0;
            end else if (drop) begin
              state    <= ACQ;
              locked   <= 1'b0;
              miss_cnt <= 4'd0;
            end else begin
              miss_cnt <= miss_cnt + 4'd1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Event pulses for the comparison made on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch   <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      mismatch   <= miss_hit;
      wrap_pulse <= wrap_hit;
    end
  end

  // Statistics; clr wins over a same-edge increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_count <= '0;
      err_count  <= 8'd0;
    end else if (clr) begin
      wrap_count <= '0;
      err_count  <= 8'd0;
    end else begin
      if (wrap_hit)
        wrap_count <= wrap_count + WRAP_W'(1);
      if (miss_hit && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

endmodule
